// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register bank.
// Imported by the synchronizer and the bank top.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, with
// single-cycle rise/fall pulses on the synchronized value.
module spi_sync_edge
    import spi_reg_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_DEPTH{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], d_i};
            prev_q <= sync_q[SYNC_DEPTH-1];
        end
    end

    assign q_o    = sync_q[SYNC_DEPTH-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral exposing a small bank of registers.
// Frame: R/W bit, address, data, MSB first.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 7,
    parameter int                NUM_REGS  = 5,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sclk,
    input  logic                         ncs,
    input  logic                         copi,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr
);

    localparam int F     = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(F + 1);
    localparam logic [CNT_W-1:0] CNT_CMD = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0] CNT_F   = CNT_W'(F);

    logic sclk_unused, sclk_rise, sclk_fall;
    logic ncs_s, ncs_rise, ncs_fall;
    logic copi_s;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk_i  (clk),
        .rst_i  (rst),
        .d_i    (sclk),
        .q_o    (sclk_unused),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_ncs_sync (
        .clk_i  (clk),
        .rst_i  (rst),
        .d_i    (ncs),
        .q_o    (ncs_s),
        .rise_o (ncs_rise),
        .fall_o (ncs_fall)
    );

    logic [SYNC_DEPTH-1:0]            copi_sync_q;
    state_e                           state_q, state_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [F-1:0]                     rx_q, rx_d, rx_nxt;
    logic [DATA_W-1:0]                tx_q, tx_d, rd_val;
    logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q, regs_d;
    logic                             wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]                wr_addr_q, wr_addr_d;
    logic [1:0]                       settle_q, settle_d;
    logic                             armed_q, armed_d;
    logic                             wr_hit;
    logic                             cmd_rw;
    logic [ADDR_W-1:0]                cmd_addr;
    logic [DATA_W-1:0]                cmd_data;

    assign copi_s   = copi_sync_q[SYNC_DEPTH-1];
    assign rx_nxt   = {rx_q[F-2:0], copi_s};
    assign cmd_rw   = rx_q[F-1];
    assign cmd_addr = rx_q[F-2 -: ADDR_W];
    assign cmd_data = rx_q[DATA_W-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        settle_d    = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
        // a low ncs left over from reset must go high before we listen
        armed_d     = armed_q | ((settle_q == 2'd2) & ncs_s);
        rd_val      = '0;
        wr_hit      = 1'b0;

        for (int i = 0; i < NUM_REGS; i++) begin
            if (rx_nxt[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs_q[i];
        end

        if (ncs_rise) begin
            if (state_q == ST_DONE && cmd_rw == RW_WRITE) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (cmd_addr == ADDR_W'(i)) begin
                        regs_d[i] = cmd_data;
                        wr_hit    = 1'b1;
                    end
                end
                wr_strobe_d = wr_hit;
                if (wr_hit) wr_addr_d = cmd_addr;
            end
            state_d = ST_IDLE;
        end else if (ncs_fall) begin
            if (armed_q) begin
                state_d = ST_CMD;
                cnt_d   = '0;
                rx_d    = '0;
                tx_d    = '0;
            end
        end else if (state_q != ST_IDLE) begin
            if (sclk_rise && cnt_q != CNT_F) begin
                cnt_d = cnt_q + 1'b1;
                rx_d  = rx_nxt;
                if (cnt_q == CNT_CMD - 1'b1) begin
                    state_d = ST_DATA;
                    if (rx_nxt[ADDR_W] == RW_READ) tx_d = rd_val;
                end
                if (cnt_q == CNT_F - 1'b1) state_d = ST_DONE;
            end else if (sclk_fall && cnt_q > CNT_CMD) begin
                tx_d = tx_q << 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            copi_sync_q <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            regs_q      <= {NUM_REGS{RESET_VAL}};
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            settle_q    <= '0;
            armed_q     <= 1'b0;
        end else begin
            copi_sync_q <= {copi_sync_q[SYNC_DEPTH-2:0], copi};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
        end
    end

    assign cipo_oe   = ~ncs_s;
    assign cipo      = cipo_oe & tx_q[DATA_W-1];
    assign reg_q     = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;

endmodule
